mixpix_sequencer: RTL and testbench
===================================

# mixpix_sequencer

Wishbone-controlled capture sequencer for the MixPix user area. It owns the single management Wishbone slave port and runs one capture per software request: a `pxl_start` pulse to the pixel macro, a wait for `pxl_done`, a start pulse to the RLBP macro, and deserialisation of the RLBP serial output into a result register. Completion raises a user interrupt. The block replaces direct Wishbone, IRQ and start/done connections from the macros to the wrapper.

## Interface
Parameters:
- `BASE_ADR`, default 32'h3000_0000: base of the 16-byte register window.
- `RESULT_W`, default 8: number of serial bits captured from the RLBP macro (1..32).

Ports:
- `wb_clk_i` input 1: the only clock.
- `wb_rst_n_i` input 1: asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` input 1 each: Wishbone classic cycle, strobe and write enable.
- `wbs_sel_i` input 4: byte selects (bytes 0–1 honoured, others ignored).
- `wbs_adr_i` input 32: byte address.
- `wbs_dat_i` input 32: write data.
- `wbs_ack_o` output 1: acknowledge.
- `wbs_dat_o` output 32: read data.
- `pxl_start_o` output 1: 1-cycle start pulse to the pixel macro.
- `pxl_done_i` input 1: pixel macro done (level or pulse, synchronous to `wb_clk_i`).
- `rlbp_start_o` output 1: 1-cycle start pulse to the RLBP macro.
- `rlbp_serial_i` input 1: RLBP serial result, MSB first.
- `irq_o` output 1: interrupt, level = `done & irq_en`.
- `busy_o` output 1: high when the FSM is not in IDLE.

## Operation
Register map (offset from `BASE_ADR`):
- 0x0 CTRL:
  - bit0 START: write 1 launches a capture; reads 0.
  - bit1 IRQ_EN: read/write.
- 0x4 STATUS:
  - bit0 BUSY (RO).
  - bit1 DONE (W1C).
  - bit2 TIMEOUT_ERR (W1C).
  - bits[5:3] FSM state code (RO).
- 0x8 TIMEOUT: bits[15:0] read/write; maximum PXL_WAIT cycles; 0 disables the timeout.
- 0xC RESULT: bits[RESULT_W-1:0] (RO); last captured value, zero-extended.

Wishbone decode:
- Hit condition: `cyc & stb` and `adr[31:4] == BASE_ADR[31:4]`; `adr[3:2]` selects the register.
- Misses are never acknowledged.
- Writes apply byte selects to bytes 0–1 only.

FSM states and codes:
- IDLE (0):
  - START write with BUSY=0 → PXL_GO.
  - START write while BUSY=1 is ignored; no flag is set.
- PXL_GO (1): `pxl_start_o`=1 for exactly this cycle; clear the timeout counter → PXL_WAIT.
- PXL_WAIT (2):
  - `pxl_done_i`=1 → RLBP_GO.
  - Otherwise, if TIMEOUT≠0 and counter==TIMEOUT-1: set TIMEOUT_ERR, leave RESULT unchanged → IDLE.
  - Otherwise increment the counter.
- RLBP_GO (3): `rlbp_start_o`=1 for this cycle; clear the bit counter → SHIFT.
- SHIFT (4):
  - Each cycle: `shreg <= {shreg[RESULT_W-2:0], rlbp_serial_i}`; bit counter increments.
  - After the RESULT_W-th sample → DONE.
- DONE (5): RESULT <= shreg; set DONE → IDLE.

Flag rules:
- If a hardware set and a W1C clear of DONE or TIMEOUT_ERR land in the same cycle, the set wins.
- DONE and TIMEOUT_ERR are sticky until cleared by software; a new capture does not clear them.

## Timing
Reset values (while `wb_rst_n_i`=0, applied asynchronously):
- All outputs are 0.
- State IDLE; CTRL, STATUS, TIMEOUT, RESULT, shreg and counters all 0.

Wishbone:
- `wbs_ack_o` rises 1 cycle after a hit and lasts 1 cycle.
- `ack` is forced low in the cycle after an ack, so back-to-back strobes take 2 cycles each.
- `wbs_dat_o` is valid while `ack`=1 and is 0 otherwise.

Capture latency (write data captured in the ack cycle, cycle T):
- `pxl_start_o` is high in T+1.
- A `pxl_done_i` first high at cycle D gives `rlbp_start_o` high at D+1.
- The first serial bit is sampled at D+2; the last at D+1+RESULT_W.
- RESULT, DONE and `irq_o` update at D+2+RESULT_W.
- `busy_o` returns low at D+3+RESULT_W.

Timeout: with TIMEOUT=N, TIMEOUT_ERR sets exactly N cycles after the `pxl_start_o` cycle if `pxl_done_i` stays low.

Other boundary cases:
- `pxl_done_i` high already in the PXL_GO cycle is not sampled; only PXL_WAIT samples it.
- Reset asserted mid-capture aborts immediately; no start pulse is emitted after reset release until a new START.

## Test plan
- Reset, then read all four registers → all 0; `irq_o`=0, `busy_o`=0.
- TIMEOUT=0, RESULT_W=8, IRQ_EN=1, START; assert `pxl_done_i` 5 cycles after `pxl_start_o`; drive serial 1,0,1,1,0,0,1,0 → RESULT=0xB2, DONE=1, `irq_o`=1. Check exact pulse cycles per the Timing section.
- TIMEOUT=10, START, hold `pxl_done_i`=0 → TIMEOUT_ERR=1 exactly 10 cycles after the pulse; `rlbp_start_o` never pulses; RESULT is unchanged.
- START during SHIFT → no second `pxl_start_o`; the capture completes normally. W1C write to DONE in the same cycle DONE sets → DONE reads 1.
- Assert `wb_rst_n_i` low in PXL_WAIT, release → state IDLE, all registers 0, no spurious pulses over 50 cycles.
- Access at `BASE_ADR`+0x10 and at another base → no ack for 20 cycles. Read/write TIMEOUT with sel=4'b0001 → only the low byte changes.

Source files
------------

// File: rtl/mixpix_sequencer_if.sv
// rtl/mixpix_sequencer_if.sv - Wishbone classic slave bundle for the MixPix capture sequencer
interface mixpix_sequencer_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/mixpix_sequencer.sv
// rtl/mixpix_sequencer.sv - Wishbone-controlled pixel/RLBP capture sequencer with IRQ
module mixpix_sequencer #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          RESULT_W = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  mixpix_sequencer_if.slave    wb,
  output logic                 pxl_start_o,
  input  logic                 pxl_done_i,
  output logic                 rlbp_start_o,
  input  logic                 rlbp_serial_i,
  output logic                 irq_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PXL_GO   = 3'd1,
    S_PXL_WAIT = 3'd2,
    S_RLBP_GO  = 3'd3,
    S_SHIFT    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                state, state_next;
  logic                  ack_q;
  logic                  hit;
  logic                  wr;
  logic [1:0]            reg_sel;
  logic                  start_req;
  logic                  clr_done, clr_err;
  logic                  set_done, set_err;
  logic                  irq_en;
  logic                  done_flag, err_flag;
  logic [15:0]           timeout;
  logic [15:0]           to_cnt;
  logic [5:0]            bit_cnt;
  logic [RESULT_W-1:0]   shreg;
  logic [RESULT_W-1:0]   result;
  logic [RESULT_W:0]     shreg_ext;
  logic [31:0]           rdata;
  logic                  unused_ok;

  assign unused_ok = ^{wb.wbs_sel_i[3:2], wb.wbs_dat_i[31:16], wb.wbs_adr_i[1:0]};

  // The master holds its request until ack, so the write is applied in the ack cycle.
  assign hit       = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q &
                     (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign wr        = ack_q & wb.wbs_we_i;
  assign reg_sel   = wb.wbs_adr_i[3:2];
  assign start_req = wr & (reg_sel == 2'd0) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
  assign clr_done  = wr & (reg_sel == 2'd1) & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];
  assign clr_err   = wr & (reg_sel == 2'd1) & wb.wbs_sel_i[0] & wb.wbs_dat_i[2];
  assign shreg_ext = {shreg, rlbp_serial_i};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    pxl_start_o  = 1'b0;
    rlbp_start_o = 1'b0;
    set_done     = 1'b0;
    set_err      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) state_next = S_PXL_GO;
      end
      S_PXL_GO: begin
        pxl_start_o = 1'b1;
        state_next  = S_PXL_WAIT;
      end
      S_PXL_WAIT: begin
        if (pxl_done_i) begin
          state_next = S_RLBP_GO;
        end else if ((timeout != 16'd0) && (to_cnt == timeout - 16'd1)) begin
          set_err    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_RLBP_GO: begin
        rlbp_start_o = 1'b1;
        state_next   = S_SHIFT;
      end
      S_SHIFT: begin
        if (bit_cnt == 6'(RESULT_W - 1)) state_next = S_DONE;
      end
      S_DONE: begin
        set_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy_o = (state != S_IDLE);
  assign irq_o  = done_flag & irq_en;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      to_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      result  <= '0;
    end else begin
      if (state == S_PXL_GO)   to_cnt <= '0;
      if (state == S_PXL_WAIT) to_cnt <= to_cnt + 16'd1;
      if (state == S_RLBP_GO)  bit_cnt <= '0;
      if (state == S_SHIFT) begin
        bit_cnt <= bit_cnt + 6'd1;
        shreg   <= shreg_ext[RESULT_W-1:0];
      end
      if (state == S_DONE)     result <= shreg;
    end
  end

  // Hardware set takes priority over a same-cycle software clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q     <= 1'b0;
      irq_en    <= 1'b0;
      timeout   <= '0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      ack_q     <= hit;
      done_flag <= set_done | (done_flag & ~clr_done);
      err_flag  <= set_err  | (err_flag  & ~clr_err);
      if (wr && (reg_sel == 2'd0) && wb.wbs_sel_i[0]) irq_en <= wb.wbs_dat_i[1];
      if (wr && (reg_sel == 2'd2)) begin
        if (wb.wbs_sel_i[0]) timeout[7:0]  <= wb.wbs_dat_i[7:0];
        if (wb.wbs_sel_i[1]) timeout[15:8] <= wb.wbs_dat_i[15:8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata[1]   = irq_en;
      2'd1: rdata[5:0] = {state, err_flag, done_flag, busy_o};
      2'd2: rdata[15:0] = timeout;
      default: rdata[RESULT_W-1:0] = result;
    endcase
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = ack_q ? rdata : 32'd0;

endmodule

// File: tb/tb_mixpix_sequencer.sv
// tb/tb_mixpix_sequencer.sv - randomized self-checking bench for mixpix_sequencer
`timescale 1ns/1ps
module tb_mixpix_sequencer;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mixpix_sequencer_if bus ();
  logic pxl_start, pxl_done, rlbp_start, rlbp_serial, irq, busy;

  mixpix_sequencer #(.BASE_ADR(BASE), .RESULT_W(W)) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .wb           (bus),
    .pxl_start_o  (pxl_start),
    .pxl_done_i   (pxl_done),
    .rlbp_start_o (rlbp_start),
    .rlbp_serial_i(rlbp_serial),
    .irq_o        (irq),
    .busy_o       (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference model of the software-visible state
  logic        m_irq_en;
  logic [15:0] m_to;
  logic [31:0] m_result;
  logic        m_done, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_irq_en = 1'b0; m_to = '0; m_result = '0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel);
    case (off)
      32'h0: if (sel[0]) m_irq_en = dat[1];
      32'h4: if (sel[0]) begin
        if (dat[1]) m_done = 1'b0;
        if (dat[2]) m_err  = 1'b0;
      end
      32'h8: begin
        if (sel[0]) m_to[7:0]  = dat[7:0];
        if (sel[1]) m_to[15:8] = dat[15:8];
      end
      default: ;
    endcase
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output int t_ack);
    logic got;
    got = 1'b0; rd = '0; t_ack = -1;
    @(posedge clk); #1;
    bus_drive(we, adr, dat, sel);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        got = 1'b1; rd = bus.wbs_dat_o; t_ack = cyc_n;
      end
    end
    check("wb_ack", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd; int t;
    wb_xfer(1'b1, BASE + off, dat, sel, rd, t);
    model_write(off, dat, sel);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd; int t;
    wb_xfer(1'b0, BASE + off, 32'd0, 4'hF, rd, t);
    check(tag, rd, exp);
  endtask

  task automatic miss_check(input string tag, input logic [31:0] adr);
    int acks;
    acks = 0;
    @(posedge clk); #1;
    bus_drive(1'b0, adr, 32'd0, 4'hF);
    repeat (20) begin
      @(negedge clk);
      if (bus.wbs_ack_o) acks++;
    end
    bus_idle();
    check(tag, acks, 0);
  endtask

  // One capture: done window [P+k, P+k+hold]; optional bus write injected at P+inj_at.
  task automatic capture(input logic [W-1:0] bits, input int k, input int hold, input int inj_at,
                         input logic [31:0] inj_off, input logic [31:0] inj_dat);
    int t, p_exp, d_exp, end_exp, p_obs, r_obs, end_obs, n_p, n_r, c, n;
    bit tmo, inj_on, inj_ack;
    logic irq_end;
    logic [31:0] rd;
    n = int'(m_to);
    p_obs = -1; r_obs = -1; end_obs = -1; n_p = 0; n_r = 0;
    inj_on = 1'b0; inj_ack = 1'b0; irq_end = 1'bx;
    wb_xfer(1'b1, BASE, {30'd0, m_irq_en, 1'b1}, 4'b0001, rd, t);
    p_exp = t + 1;
    if (k + hold < 1) d_exp = -1;
    else d_exp = (k < 1) ? p_exp + 1 : p_exp + k;
    tmo = (n != 0) && ((d_exp < 0) || (d_exp > p_exp + n));
    end_exp = tmo ? p_exp + n + 1 : d_exp + 3 + W;
    for (int i = 0; i < 400; i++) begin
      c = cyc_n;
      pxl_done = (c >= p_exp + k) && (c <= p_exp + k + hold);
      rlbp_serial = (!tmo && c >= d_exp + 2 && c <= d_exp + 1 + W) ? bits[W - 1 - (c - d_exp - 2)] : 1'b0;
      if (inj_at >= 0 && c == p_exp + inj_at) begin
        bus_drive(1'b1, BASE + inj_off, inj_dat, 4'b0001);
        inj_on = 1'b1;
      end else if (inj_on && inj_ack) begin
        bus_idle();
        inj_on = 1'b0;
      end
      @(negedge clk);
      if (pxl_start)  begin n_p++; p_obs = c; end
      if (rlbp_start) begin n_r++; r_obs = c; end
      if (inj_on && bus.wbs_ack_o) inj_ack = 1'b1;
      if (!busy && c > p_exp) begin end_obs = c; irq_end = irq; break; end
      @(posedge clk); #1;
    end
    pxl_done = 1'b0; rlbp_serial = 1'b0; bus_idle();
    check("pxl_start_cycle", p_obs, p_exp);
    check("pxl_start_count", n_p, 1);
    check("busy_low_cycle", end_obs, end_exp);
    if (tmo) begin
      check("rlbp_count_tmo", n_r, 0);
    end else begin
      check("rlbp_start_cycle", r_obs, d_exp + 1);
      check("rlbp_start_count", n_r, 1);
    end
    if (inj_at >= 0) begin
      check("inj_ack", {31'd0, inj_ack}, 32'd1);
      model_write(inj_off, inj_dat, 4'b0001);
    end
    if (tmo) m_err = 1'b1;
    else begin
      m_result = 32'(bits);
      m_done = 1'b1;
    end
    check("irq_at_end", {31'd0, irq_end}, {31'd0, m_done & m_irq_en});
    rd_check("result", 32'hC, m_result);
    rd_check("status", 32'h4, {29'd0, m_err, m_done, 1'b0});
  endtask

  int pulses;
  logic [W-1:0] rbits;
  int rk, rhold;

  initial begin
    bus_idle();
    pxl_done = 1'b0; rlbp_serial = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_pulses", {30'd0, pxl_start, rlbp_start}, 0);
    check("rst_ack", {31'd0, bus.wbs_ack_o}, 0);
    rst_n = 1'b1;
    rd_check("rst_ctrl", 32'h0, 0);
    rd_check("rst_status", 32'h4, 0);
    rd_check("rst_timeout", 32'h8, 0);
    rd_check("rst_result", 32'hC, 0);

    // Directed capture: 1,0,1,1,0,0,1,0 -> 0xB2
    wb_write(32'h8, 32'd0, 4'b0011);
    wb_write(32'h0, 32'h2, 4'b0001);
    rd_check("ctrl_irq_en", 32'h0, 32'h2);
    capture(8'b1011_0010, 5, 0, -1, 0, 0);
    check("irq_level", {31'd0, irq}, 1);

    // Timeout, including done only in the PXL_GO cycle
    wb_write(32'h8, 32'd10, 4'b0011);
    capture(8'h5A, 1000, 0, -1, 0, 0);
    wb_write(32'h4, 32'h6, 4'b0001);
    capture(8'h3C, 0, 0, -1, 0, 0);
    wb_write(32'h8, 32'd1, 4'b0011);
    capture(8'hC3, 1, 0, -1, 0, 0);
    wb_write(32'h4, 32'h6, 4'b0001);
    rd_check("status_cleared", 32'h4, 0);
    check("irq_cleared", {31'd0, irq}, 0);

    // START during SHIFT is ignored; W1C colliding with DONE set loses
    wb_write(32'h8, 32'd0, 4'b0011);
    capture(8'h96, 3, 0, 3 + 2, 32'h0, {30'd0, m_irq_en, 1'b1});
    wb_write(32'h4, 32'h2, 4'b0001);
    capture(8'h69, 4, 2, 4 + 1 + W, 32'h4, 32'h2);
    wb_write(32'h4, 32'h2, 4'b0001);
    rd_check("w1c_done", 32'h4, 0);

    for (int r = 0; r < 8; r++) begin
      wb_write(32'h0, {30'd0, 1'($urandom_range(0, 1)), 1'b0}, 4'b0001);
      wb_write(32'h8, ($urandom_range(0, 1) != 0) ? 32'd0 : 32'($urandom_range(1, 12)), 4'b0011);
      if ($urandom_range(0, 1) != 0) wb_write(32'h4, 32'h6, 4'b0001);
      rbits = W'($urandom());
      rk = $urandom_range(1, 8);
      rhold = $urandom_range(0, 3);
      capture(rbits, rk, rhold, -1, 0, 0);
    end

    // Byte selects: only bytes 0-1 honoured
    wb_write(32'h8, 32'hFFFF, 4'b0011);
    wb_write(32'h8, 32'h1234, 4'b0001);
    rd_check("sel_low_byte", 32'h8, {16'd0, m_to});
    check("sel_model", {16'd0, m_to}, 32'hFF34);
    wb_write(32'h8, 32'hABCD_ABCD, 4'b1100);
    rd_check("sel_upper_ignored", 32'h8, 32'hFF34);

    miss_check("miss_offset", BASE + 32'h10);
    miss_check("miss_base", 32'h3100_0000);

    // Reset in PXL_WAIT
    wb_write(32'h8, 32'd0, 4'b0011);
    wb_write(32'h0, 32'h2, 4'b0001);
    wb_write(32'h0, 32'h3, 4'b0001);
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (pxl_start || rlbp_start || busy || irq) pulses++;
    end
    check("post_rst_quiet", pulses, 0);
    rd_check("post_rst_ctrl", 32'h0, 0);
    rd_check("post_rst_status", 32'h4, 0);
    rd_check("post_rst_timeout", 32'h8, 0);
    rd_check("post_rst_result", 32'hC, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
